// File: rtl/shift_sequencer.sv
// Multi-cycle shift/normalize sequencer wrapped around a 16-bit datapath whose
// shifter moves at most 7 bit positions per cycle. Long shifts and mantissa
// normalization are broken into steps of up to MAX_STEP bits, one per RUN cycle.
// Requests and results use valid/ready handshakes.
module shift_sequencer #(
  // Bits shifted per RUN cycle; legal range 1..7 (shifter distance is 3 bits)
  parameter int unsigned MAX_STEP = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_value,
  input  logic [1:0]  in_op,
  input  logic [4:0]  in_amount,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_value,
  output logic [4:0]  out_count,
  output logic        out_zero,
  output logic        busy
);

  localparam logic [1:0] OpShl  = 2'b00;
  localparam logic [1:0] OpShr  = 2'b01;
  localparam logic [1:0] OpNorm = 2'b10;
  localparam logic [1:0] OpPass = 2'b11;

  localparam logic [4:0] MaxStepW = 5'(MAX_STEP);
  localparam logic [4:0] FullW    = 5'd16;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  rem_q, rem_d;
  logic [4:0]  count_q, count_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_value_q, out_value_d;
  logic [4:0]  out_count_q, out_count_d;
  logic        out_zero_q, out_zero_d;

  logic [3:0]  lz;
  logic [2:0]  shift_step;
  logic [2:0]  norm_step;
  logic [2:0]  step;
  logic [15:0] shifted;

  // Leading-zero count of the working value; highest set bit wins. Zero value
  // is handled separately by the FSM, so lz is don't-care there.
  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (value_q[i]) lz = 4'(15 - i);
    end
  end

  // Step size for this cycle, clamped to MAX_STEP
  always_comb begin
    shift_step = (rem_q > MaxStepW) ? MaxStepW[2:0] : rem_q[2:0];
    norm_step  = ({1'b0, lz} > MaxStepW) ? MaxStepW[2:0] : lz[2:0];
    step       = (op_q == OpNorm) ? norm_step : shift_step;
  end

  // 3-bit-distance shifter datapath; normalize shares the left-shift path
  always_comb begin
    shifted = op_q[0] ? (value_q >> step) : (value_q << step);
  end

  // Next-state logic: accept in IDLE, step in RUN, hold result in DONE
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    op_d        = op_q;
    rem_d       = rem_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_count_d = out_count_q;
    out_zero_d  = out_zero_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          value_d = in_value;
          op_d    = in_op;
          // Anything past 16 positions clears the word anyway
          rem_d   = (in_amount > FullW) ? FullW : in_amount;
          count_d = 5'd0;
          if (in_op == OpPass) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            out_value_d = in_value;
            out_count_d = 5'd0;
            out_zero_d  = (in_value == 16'h0000);
          end else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        // Finish when nothing is left to shift; otherwise take one step
        if ((op_q == OpNorm) ? (value_q == 16'h0000 || norm_step == 3'd0)
                             : (rem_q == 5'd0)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_value_d = value_q;
          out_count_d = count_q;
          out_zero_d  = (value_q == 16'h0000);
        end else begin
          value_d = shifted;
          count_d = count_q + {2'b00, step};
          if (op_q == OpShl || op_q == OpShr) rem_d = rem_q - {2'b00, step};
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      value_q     <= 16'h0000;
      op_q        <= OpShl;
      rem_q       <= 5'd0;
      count_q     <= 5'd0;
      out_valid_q <= 1'b0;
      out_value_q <= 16'h0000;
      out_count_q <= 5'd0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_count_q <= out_count_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_count = out_count_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: each request pushes its expected
// result (value, count, zero flag, accept-to-valid latency) and a monitor pops
// and compares it when the result handshake fires.
module tb_shift_sequencer;

  localparam int MaxStep = 7;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [1:0]  in_op;
  logic [4:0]  in_amount;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_value;
  logic [4:0]  out_count;
  logic        out_zero;
  logic        busy;

  typedef struct {
    logic [15:0] value;
    logic [4:0]  count;
    logic        zero;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  bit   seen = 0;

  shift_sequencer #(.MAX_STEP(MaxStep)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_op     (in_op),
    .in_amount (in_amount),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_count (out_count),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: closed-form result and latency in cycles, accept edge included
  function automatic exp_t model(input logic [15:0] v, input logic [1:0] op,
                                 input logic [4:0] amt);
    exp_t e;
    int a;
    int lz;
    logic [15:0] t;
    e.acc = 0;
    case (op)
      2'b00, 2'b01: begin
        a = (amt > 5'd16) ? 16 : int'(amt);
        e.value = op[0] ? (v >> a) : (v << a);
        e.count = 5'(a);
        e.lat   = 2 + (a + MaxStep - 1) / MaxStep;
      end
      2'b10: begin
        if (v == 16'h0000) begin
          e.value = 16'h0000;
          e.count = 5'd0;
          e.lat   = 2;
        end else begin
          t  = v;
          lz = 0;
          while (!t[15]) begin
            t = t << 1;
            lz++;
          end
          e.value = t;
          e.count = 5'(lz);
          e.lat   = 2 + (lz + MaxStep - 1) / MaxStep;
        end
      end
      default: begin
        e.value = v;
        e.count = 5'd0;
        e.lat   = 1;
      end
    endcase
    e.zero = (e.value == 16'h0000);
    return e;
  endfunction

  // Monitor: compare on the result handshake, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_value", 32'(out_value), 32'(e.value));
          check("out_count", 32'(out_count), 32'(e.count));
          check("out_zero", 32'(out_zero), 32'(e.zero));
          check("latency", 32'(first_cyc - e.acc + 1), 32'(e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  // Issue one request from the posedge+1 phase; optionally score it
  task automatic do_req(input logic [15:0] v, input logic [1:0] op, input logic [4:0] amt,
                        input bit push);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    e = model(v, op, amt);
    in_valid  = 1'b1;
    in_value  = v;
    in_op     = op;
    in_amount = amt;
    @(posedge clk);
    #1;
    e.acc = cyc;
    in_valid  = 1'b0;
    in_value  = 16'($urandom);
    in_op     = 2'($urandom);
    in_amount = 5'($urandom);
    if (push) sb.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("result_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    int n;
    logic [15:0] v;
    logic [1:0] op;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_value  = 16'h0000;
    in_op     = 2'b00;
    in_amount = 5'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_value", 32'(out_value), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    do_req(16'h0001, 2'b00, 5'd9, 1'b1);  wait_done();
    do_req(16'hDEAD, 2'b01, 5'd20, 1'b1); wait_done();
    do_req(16'h0003, 2'b10, 5'd0, 1'b1);  wait_done();
    do_req(16'h0000, 2'b10, 5'd3, 1'b1);  wait_done();
    do_req(16'h1234, 2'b11, 5'd5, 1'b1);  wait_done();
    do_req(16'h1234, 2'b00, 5'd0, 1'b1);  wait_done();
    do_req(16'h8000, 2'b10, 5'd0, 1'b1);  wait_done();
    do_req(16'h0001, 2'b10, 5'd0, 1'b1);  wait_done();
    do_req(16'hFFFF, 2'b00, 5'd16, 1'b1); wait_done();
    do_req(16'h8001, 2'b01, 5'd15, 1'b1); wait_done();
    do_req(16'h0000, 2'b11, 5'd0, 1'b1);  wait_done();

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    e = model(16'h00F0, 2'b01, 5'd4);
    do_req(16'h00F0, 2'b01, 5'd4, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_hold_value", 32'(out_value), 32'(e.value));
      check("bp_hold_count", 32'(out_count), 32'(e.count));
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    wait_done();
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);

    // Async reset in the middle of a long shift
    do_req(16'hFFFF, 2'b00, 5'd16, 1'b0);
    @(posedge clk);
    #1;
    check("mid_run_busy", 32'(busy), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_value", 32'(out_value), 32'd0);
    check("arst_out_count", 32'(out_count), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("arst_no_output", 32'(out_valid), 32'd0);
    end
    do_req(16'h00FF, 2'b00, 5'd12, 1'b1); wait_done();

    // Random mix of all ops
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      v  = 16'($urandom);
      if (op == 2'b10) v = v >> $urandom_range(0, 16);
      do_req(v, op, 5'($urandom_range(0, 31)), 1'b1);
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
